// File: rtl/udp_rx_pkg.sv
// Shared definitions for the UDP receive ping-pong buffer.
// Covers the FSM encodings, the header size and the default bank depth.
package udp_rx_pkg;

    localparam int DEF_ADDR_W    = 9;
    localparam int UDP_HDR_BYTES = 8;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_DROP = 2'd2
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_READ = 1'b1
    } rstate_t;

endpackage

// File: rtl/udp_rx_dpram.sv
// Simple dual-port RAM with one write port and one read port.
// The read is registered, so data appears one cycle after i_re.
module udp_rx_dpram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_q <= r_mem[i_raddr];
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/udp_rx_buffer.sv
// Two-bank ping-pong buffer that stores UDP payload frames and replays them on request.
// A frame is committed only when it is complete and its length is legal; otherwise it is dropped and counted.
module udp_rx_buffer
    import udp_rx_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic        i_eth_rx_clk,
    input  logic        clr,
    input  logic        i_rx_sof,
    input  logic [31:0] i_rx_data,
    input  logic        i_rx_data_valid,
    input  logic [15:0] i_rx_data_length,
    input  logic        i_rx_end,
    input  logic        i_rd_en,
    output logic [31:0] o_rd_data,
    output logic        o_rd_valid,
    output logic        o_rd_last,
    output logic        o_frame_ready,
    output logic [15:0] o_frame_bytes,
    output logic [15:0] o_drop_cnt
);

    localparam logic [16:0] MAX_BYTES = 17'(4 * (2**ADDR_W));

    wstate_t           r_wstate, w_wnext;
    rstate_t           r_rstate, w_rnext;
    logic              r_end_d;
    logic              r_wr_bank, r_rd_bank;
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic              r_trunc;
    logic [1:0]        r_full;
    logic [15:0]       r_bytes [2];
    logic [ADDR_W:0]   r_words [2];
    logic [15:0]       r_drop_cnt;
    logic              r_rd_valid, r_rd_last;

    logic              w_end_rise, w_len_ok;
    logic [16:0]       w_bytes;
    logic [ADDR_W:0]   w_words;
    logic              w_we, w_ptr_clr, w_trunc_set, w_commit, w_drop;
    logic              w_rd_acc, w_rd_is_last, w_release;
    logic [31:0]       w_ram_q;

    assign w_end_rise = i_rx_end & ~r_end_d;
    assign w_bytes    = {1'b0, i_rx_data_length} - 17'(UDP_HDR_BYTES);
    assign w_len_ok   = (i_rx_data_length > 16'(UDP_HDR_BYTES)) && (w_bytes <= MAX_BYTES);
    assign w_words    = (ADDR_W+1)'((w_bytes + 17'd3) >> 2);

    // Data and end edge are handled independently so a word landing with the end edge is kept.
    always_comb begin
        w_wnext     = r_wstate;
        w_we        = 1'b0;
        w_ptr_clr   = 1'b0;
        w_trunc_set = 1'b0;
        w_commit    = 1'b0;
        w_drop      = 1'b0;
        if (i_rx_sof) begin
            w_ptr_clr = 1'b1;
            w_wnext   = r_full[r_wr_bank] ? W_DROP : W_FILL;
        end else begin
            case (r_wstate)
                W_FILL: begin
                    if (i_rx_data_valid) begin
                        if (r_wr_ptr[ADDR_W]) w_trunc_set = 1'b1;
                        else                  w_we        = 1'b1;
                    end
                    if (w_end_rise) begin
                        if (!r_trunc && !w_trunc_set && w_len_ok) w_commit = 1'b1;
                        else                                      w_drop   = 1'b1;
                        w_wnext = W_IDLE;
                    end
                end
                W_DROP: begin
                    if (w_end_rise) begin
                        w_drop  = 1'b1;
                        w_wnext = W_IDLE;
                    end
                end
                default: w_wnext = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_eth_rx_clk) begin
        if (!clr) begin
            r_wstate   <= W_IDLE;
            r_end_d    <= 1'b0;
            r_wr_ptr   <= '0;
            r_trunc    <= 1'b0;
            r_wr_bank  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_wstate <= w_wnext;
            r_end_d  <= i_rx_end;
            if (w_ptr_clr)      r_wr_ptr <= '0;
            else if (w_we)      r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_ptr_clr)        r_trunc <= 1'b0;
            else if (w_trunc_set) r_trunc <= 1'b1;
            if (w_commit) r_wr_bank <= ~r_wr_bank;
            if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_eth_rx_clk) begin
        if (w_commit) begin
            r_bytes[r_wr_bank] <= w_bytes[15:0];
            r_words[r_wr_bank] <= w_words;
        end
    end

    assign w_rd_acc     = i_rd_en & r_full[r_rd_bank];
    assign w_rd_is_last = ({1'b0, r_rd_ptr} == r_words[r_rd_bank] - 1'b1);
    assign w_release    = w_rd_acc & w_rd_is_last;

    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_rd_acc && !w_rd_is_last) w_rnext = R_READ;
            R_READ:  if (w_release) w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    // Commit targets the free bank and release the full one, so they never collide.
    always_ff @(posedge i_eth_rx_clk) begin
        if (!clr) begin
            r_rstate   <= R_IDLE;
            r_rd_bank  <= 1'b0;
            r_rd_ptr   <= '0;
            r_full     <= 2'b00;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            r_rstate   <= w_rnext;
            r_rd_valid <= w_rd_acc;
            r_rd_last  <= w_release;
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
                r_rd_ptr  <= '0;
            end else if (w_rd_acc) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
            for (int b = 0; b < 2; b++) begin
                if (w_commit && r_wr_bank == 1'(b))        r_full[b] <= 1'b1;
                else if (w_release && r_rd_bank == 1'(b))  r_full[b] <= 1'b0;
            end
        end
    end

    udp_rx_dpram #(
        .AW (ADDR_W + 1),
        .DW (32)
    ) u_ram (
        .i_clk   (i_eth_rx_clk),
        .i_we    (w_we),
        .i_waddr ({r_wr_bank, r_wr_ptr[ADDR_W-1:0]}),
        .i_wdata (i_rx_data),
        .i_re    (w_rd_acc),
        .i_raddr ({r_rd_bank, r_rd_ptr}),
        .o_rdata (w_ram_q)
    );

    // RAM output is not reset, so gate it to keep the data bus at 0 when idle.
    assign o_rd_data     = r_rd_valid ? w_ram_q : 32'd0;
    assign o_rd_valid    = r_rd_valid;
    assign o_rd_last     = r_rd_last;
    assign o_frame_ready = r_full[r_rd_bank];
    assign o_frame_bytes = r_full[r_rd_bank] ? r_bytes[r_rd_bank] : 16'd0;
    assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_udp_rx_buffer.sv
// Directed bench for udp_rx_buffer: store, replay, drop, restart and reset scenarios.
module tb_udp_rx_buffer;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        sof = 1'b0;
    logic [31:0] din = '0;
    logic        vld = 1'b0;
    logic [15:0] len = '0;
    logic        rend = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid, rd_last, ready;
    logic [15:0] fbytes, drops;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_w [0:3];

    udp_rx_buffer dut (
        .i_eth_rx_clk     (clk),
        .clr              (clr),
        .i_rx_sof         (sof),
        .i_rx_data        (din),
        .i_rx_data_valid  (vld),
        .i_rx_data_length (len),
        .i_rx_end         (rend),
        .i_rd_en          (rd_en),
        .o_rd_data        (rd_data),
        .o_rd_valid       (rd_valid),
        .o_rd_last        (rd_last),
        .o_frame_ready    (ready),
        .o_frame_bytes    (fbytes),
        .o_drop_cnt       (drops)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b0;
        tick();
        clr = 1'b1;
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        tick();
        sof = 1'b0;
    endtask

    task automatic push(input logic [31:0] w);
        din = w;
        vld = 1'b1;
        tick();
        vld = 1'b0;
    endtask

    task automatic fin(input logic [15:0] l);
        len  = l;
        rend = 1'b1;
        tick();
        rend = 1'b0;
    endtask

    task automatic rd_burst(input int n, input string tag);
        rd_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == n - 1) rd_en = 1'b0;
            chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
            chk({tag, "_dat"}, rd_data, exp_w[i]);
            chk({tag, "_last"}, 32'(rd_last), (i == n - 1) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rdy"},   32'(ready),    32'd0);
        chk({tag, "_bytes"}, 32'(fbytes),   32'd0);
        chk({tag, "_drop"},  32'(drops),    32'd0);
        chk({tag, "_vld"},   32'(rd_valid), 32'd0);
        chk({tag, "_last"},  32'(rd_last),  32'd0);
        chk({tag, "_dat"},   rd_data,       32'd0);
    endtask

    initial begin
        tick();
        tick();
        chk_idle("rst");
        clr = 1'b1;

        // read request with nothing committed is ignored
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("norq_vld", 32'(rd_valid), 32'd0);

        // 4-word frame, length 24
        pulse_sof();
        push(32'h01020304); push(32'h05060708); push(32'h090A0B0C); push(32'h0D0E0F10);
        fin(16'd24);
        chk("f4_rdy", 32'(ready), 32'd1);
        chk("f4_bytes", 32'(fbytes), 32'd16);
        exp_w[0] = 32'h01020304; exp_w[1] = 32'h05060708;
        exp_w[2] = 32'h090A0B0C; exp_w[3] = 32'h0D0E0F10;
        rd_burst(4, "f4");
        chk("f4_done_rdy", 32'(ready), 32'd0);

        // 5-byte frame, zero-padded tail
        do_reset();
        pulse_sof();
        push(32'h01020304); push(32'h05000000);
        fin(16'd13);
        chk("f5_bytes", 32'(fbytes), 32'd5);
        exp_w[0] = 32'h01020304; exp_w[1] = 32'h05000000;
        rd_burst(2, "f5");

        // three frames, no reads: third is dropped
        do_reset();
        pulse_sof(); push(32'hA0000001); push(32'hA0000002); fin(16'd16);
        pulse_sof(); push(32'hB0000001); fin(16'd12);
        pulse_sof(); push(32'hC0000001); fin(16'd12);
        chk("f3_drop", 32'(drops), 32'd1);
        chk("f3_bytes1", 32'(fbytes), 32'd8);
        exp_w[0] = 32'hA0000001; exp_w[1] = 32'hA0000002;
        rd_burst(2, "f3a");
        chk("f3_rdy2", 32'(ready), 32'd1);
        chk("f3_bytes2", 32'(fbytes), 32'd4);
        exp_w[0] = 32'hB0000001;
        rd_burst(1, "f3b");
        chk("f3_empty", 32'(ready), 32'd0);

        // restart: second sof discards the partial frame
        do_reset();
        pulse_sof(); push(32'hDEAD0001); push(32'hDEAD0002); push(32'hDEAD0003);
        pulse_sof(); push(32'h11223344); push(32'h55667788);
        fin(16'd16);
        chk("rs_drop", 32'(drops), 32'd0);
        chk("rs_bytes", 32'(fbytes), 32'd8);
        exp_w[0] = 32'h11223344; exp_w[1] = 32'h55667788;
        rd_burst(2, "rs");
        chk("rs_empty", 32'(ready), 32'd0);

        // commit coincident with the final read of the other bank
        do_reset();
        pulse_sof(); push(32'h11111111); push(32'h22222222); fin(16'd16);
        pulse_sof(); push(32'h33333331); push(32'h33333332); push(32'h33333333);
        rd_en = 1'b1;
        tick();
        chk("cc_w0", rd_data, 32'h11111111);
        len  = 16'd20;
        rend = 1'b1;
        tick();
        rd_en = 1'b0;
        rend  = 1'b0;
        chk("cc_w1", rd_data, 32'h22222222);
        chk("cc_last", 32'(rd_last), 32'd1);
        chk("cc_rdy", 32'(ready), 32'd1);
        chk("cc_bytes", 32'(fbytes), 32'd12);
        exp_w[0] = 32'h33333331; exp_w[1] = 32'h33333332; exp_w[2] = 32'h33333333;
        rd_burst(3, "cc");

        // oversize frame: 513 words, length 2060
        do_reset();
        pulse_sof();
        for (int i = 0; i < 513; i++) push(32'(i));
        fin(16'd2060);
        chk("ov_drop", 32'(drops), 32'd1);
        chk("ov_rdy", 32'(ready), 32'd0);
        do_reset();
        chk_idle("ov_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udp_rx_buffer.md
UDP_RX_BUFFER -- requirements
Module: udp_rx_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning word-address width per bank (512 x 32-bit words).
REQ-002 SHALL have port i_eth_rx_clk, input, 1, the GMII receive clock; all logic is on its rising edge.
REQ-003 SHALL have port clr, input, 1, a synchronous active-low reset.
REQ-004 SHALL have port i_rx_sof, input, 1, a one-cycle frame-start pulse (the IP-type-valid strobe from the UDP receiver).
REQ-005 SHALL have port i_rx_data, input, 32, a payload word, first byte in [31:24], zero-padded on the tail.
REQ-006 SHALL have port i_rx_data_valid, input, 1, which marks i_rx_data as valid for one cycle.
REQ-007 SHALL have port i_rx_data_length, input, 16, the UDP length field, including the 8-byte header.
REQ-008 SHALL have port i_rx_end, input, 1, the frame-complete level; only its rising edge is used.
REQ-009 SHALL have port i_rd_en, input, 1, a user read request.
REQ-010 SHALL have port o_rd_data, output, 32, the read word.
REQ-011 SHALL have port o_rd_valid, output, 1, which qualifies o_rd_data.
REQ-012 SHALL have port o_rd_last, output, 1, which marks the last word of a frame, coincident with o_rd_valid.
REQ-013 SHALL have port o_frame_ready, output, 1, high while at least one committed frame is unread.
REQ-014 SHALL have port o_frame_bytes, output, 16, the payload byte count of the frame at the read head.
REQ-015 SHALL have port o_drop_cnt, output, 16, a saturating count of dropped frames.

Function
REQ-016 SHALL hold two banks (ping-pong) in one 2*2^ADDR_W x 32 RAM, with the bank select as the address MSB.
REQ-017 SHALL run a write FSM with states W_IDLE, W_FILL and W_DROP.
REQ-018 On i_rx_sof the write FSM SHALL reset wr_ptr to 0 and go to W_FILL if the write bank is free, else to W_DROP; an sof in W_FILL discards the partial frame and restarts it.
REQ-019 In W_FILL, each i_rx_data_valid SHALL write RAM[wr_bank, wr_ptr] and increment wr_ptr; a valid with wr_ptr == 2^ADDR_W-1 already written SHALL set a truncate flag and discard further words.
REQ-020 On the i_rx_end rising edge in W_FILL the FSM SHALL commit if no truncate flag and bytes = i_rx_data_length-8 lies in 1..4*2^ADDR_W; otherwise it SHALL drop. In both cases it returns to W_IDLE.
REQ-021 Commit SHALL mark the bank full, latch bytes and words = ceil(bytes/4) for it, and toggle wr_bank.
REQ-022 A drop SHALL increment o_drop_cnt, saturating at 0xFFFF; the W_DROP end edge and an sof received while the bank is busy both count as a drop.
REQ-023 A data valid or end edge in W_IDLE SHALL be ignored and SHALL NOT count as a drop.
REQ-024 SHALL run a read FSM with states R_IDLE and R_READ; rd_bank starts at 0 and always points to the oldest full bank.
REQ-025 o_frame_ready SHALL equal full[rd_bank]; o_frame_bytes SHALL equal bytes[rd_bank] while ready, else 0.
REQ-026 i_rd_en SHALL be accepted only when o_frame_ready is high; i_rd_en while not ready SHALL be ignored.
REQ-027 Each accepted i_rd_en SHALL issue one RAM read; o_rd_valid and o_rd_data follow exactly 1 cycle later, and i_rd_en may be held for back-to-back reads.
REQ-028 The read of word words-1 SHALL assert o_rd_last, clear full[rd_bank], toggle rd_bank and reset rd_ptr, all on the read-issue cycle, so the following cycle sees the next frame.
REQ-029 A commit and a release in the same cycle SHALL both take effect.
REQ-030 A write to the bank being read is impossible by construction, because the write FSM requires !full[wr_bank].

Reset
REQ-031 clr low SHALL, at the next clock edge, force both FSMs to idle, clear full[1:0], wr_bank, rd_bank, the pointers and the truncate flag, and drive every output to 0, including o_drop_cnt.
REQ-032 RAM contents SHALL NOT be reset; a reset mid-frame or mid-read SHALL discard that frame without counting a drop.

Structure
REQ-033 A shared package udp_rx_pkg SHALL hold the FSM state encodings, UDP_HDR_BYTES=8 and the default ADDR_W.
REQ-034 Storage SHALL be a single sub-module udp_rx_dpram: simple dual-port, with one write port, one read port and a registered read with 1-cycle latency.

Verification
REQ-035 Scenario: sof, 4 words 0x01020304..0x0D0E0F10, length=24, end edge -> o_frame_ready=1 and o_frame_bytes=16; 4 reads return the same words with o_rd_last on the 4th, after which o_frame_ready=0.
REQ-036 Scenario: length=13 (5 bytes), 2 words -> o_frame_bytes=5; the 2nd word reads 0x05000000 with o_rd_last asserted.
REQ-037 Scenario: three frames arrive without reads -> frames 1 and 2 are stored, frame 3 is dropped (o_drop_cnt=1), and reads return frame 1 then frame 2.
REQ-038 Scenario: sof, 3 words, then a new sof followed by 2 words and an end edge at length=16 -> only the 2-word frame is committed and o_drop_cnt=0.
REQ-039 Scenario: a frame end edge lands on the same cycle as the final read of the other bank -> both take effect, and o_frame_ready stays 1 for the new frame.
REQ-040 Scenario: 513 words at length=2060, then end -> the frame is dropped (o_drop_cnt=1); a following reset with clr=0 for 1 cycle -> all outputs read 0.
